// File: rtl/multiphase_hr_dpwm.sv
// Multi-channel phase-shifted high-resolution DPWM: one shared coarse counter,
// per-channel duty/phase, complementary gates with dead time, double-buffered config.
module multiphase_hr_dpwm #(
  parameter int N_CH         = 4,
  parameter int Dc_length    = 13,
  parameter int DE_bits      = 6,
  parameter int Count_length = Dc_length - DE_bits
) (
  input  logic                           clk_base,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           load,
  input  logic [Count_length-1:0]        Period,
  input  logic [N_CH*Count_length-1:0]   Phase,
  input  logic [N_CH*Dc_length-1:0]      H_on,
  input  logic [Dc_length-1:0]           DeadTime,
  output logic [N_CH-1:0]                H_DPWM,
  output logic [N_CH-1:0]                L_DPWM,
  output logic [N_CH*DE_bits-1:0]        H_fine,
  output logic [DE_bits-1:0]             DT_fine,
  output logic [3:0]                     Flags_out
);
  localparam int CW = Count_length;

  logic [CW-1:0]             sh_period, act_period;
  logic [N_CH*CW-1:0]        sh_phase, act_phase;
  logic [N_CH*Dc_length-1:0] sh_hon, act_hon;
  logic [Dc_length-1:0]      sh_dt, act_dt;
  logic                      load_pending, valid, cfg_err, upd_q, start_q;
  logic [CW-1:0]             cnt;
  logic [N_CH-1:0]           h_q, l_q, h_cmp, l_cmp, sat_ch;
  logic                      load_ok, running, wrap, apply;

  always_comb begin
    load_ok = (Period >= CW'(2));
    for (int k = 0; k < N_CH; k++) begin
      if (Phase[k*CW +: CW] >= Period) load_ok = 1'b0;
    end
  end

  assign running = en & valid;
  assign wrap    = (cnt == act_period - CW'(1));
  // When the counter is idle there is no wrap to wait for, so apply at once.
  assign apply   = load_pending & (~running | wrap);

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [CW:0]   cnt_x, ph_x, p_x, ch;
    logic [CW+1:0] hc, hc_cl, dc, p_w, lo, ch_w;

    assign cnt_x = {1'b0, cnt};
    assign ph_x  = {1'b0, act_phase[k*CW +: CW]};
    assign p_x   = {1'b0, act_period};
    assign ch    = (cnt_x >= ph_x) ? (cnt_x - ph_x) : (cnt_x + p_x - ph_x);

    assign hc    = {2'b00, act_hon[k*Dc_length + DE_bits +: CW]};
    assign dc    = {2'b00, act_dt[Dc_length-1:DE_bits]};
    assign p_w   = {2'b00, act_period};
    assign ch_w  = {1'b0, ch};

    assign sat_ch[k] = (hc >= p_w);
    assign hc_cl     = sat_ch[k] ? p_w : hc;
    assign lo        = hc_cl + dc;

    assign h_cmp[k] = (ch_w < hc_cl);
    assign l_cmp[k] = (ch_w >= lo) && ((ch_w + dc) < p_w);

    assign H_fine[k*DE_bits +: DE_bits] = act_hon[k*Dc_length +: DE_bits];
  end

  always_ff @(posedge clk_base) begin
    if (rst) begin
      sh_period    <= '0;
      sh_phase     <= '0;
      sh_hon       <= '0;
      sh_dt        <= '0;
      act_period   <= '0;
      act_phase    <= '0;
      act_hon      <= '0;
      act_dt       <= '0;
      load_pending <= 1'b0;
      valid        <= 1'b0;
      cfg_err      <= 1'b0;
      upd_q        <= 1'b0;
      start_q      <= 1'b0;
      cnt          <= '0;
      h_q          <= '0;
      l_q          <= '0;
    end else begin
      if (load && load_ok) begin
        sh_period <= Period;
        sh_phase  <= Phase;
        sh_hon    <= H_on;
        sh_dt     <= DeadTime;
      end
      if (load && !load_ok) cfg_err <= 1'b1;
      // Active copy takes the pre-edge shadow, so a coincident load waits a period.
      if (apply) begin
        act_period <= sh_period;
        act_phase  <= sh_phase;
        act_hon    <= sh_hon;
        act_dt     <= sh_dt;
        valid      <= 1'b1;
      end
      load_pending <= (load & load_ok) | (load_pending & ~apply);
      cnt          <= running ? (wrap ? '0 : cnt + CW'(1)) : '0;
      h_q          <= running ? h_cmp : '0;
      l_q          <= running ? l_cmp : '0;
      start_q      <= running && (cnt == '0);
      upd_q        <= apply;
    end
  end

  assign H_DPWM    = h_q;
  assign L_DPWM    = l_q;
  assign DT_fine   = act_dt[DE_bits-1:0];
  assign Flags_out = {cfg_err, valid & (|sat_ch), upd_q, start_q};
endmodule
